// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the async FIFO: Gray encode/decode,
// depth derivation and the full-compare target.
package fifo_pkg;

    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

    // Callers zero-extend their pointer; upper zero bits leave the result unchanged.
    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // A Gray pointer exactly one lap ahead differs only in its top two bits.
    function automatic ptr_word_t full_target(input ptr_word_t g, input int w);
        return g ^ (ptr_word_t'(2'b11) << (w - 2));
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter, XOR prefix from the MSB down.
module fifo_gray2bin #(
    parameter int W = 6
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    assign bin_o[W-1] = gray_i[W-1];

    for (genvar i = W - 2; i >= 0; i--) begin : g_prefix
        assign bin_o[i] = bin_o[i+1] ^ gray_i[i];
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer stage of the async FIFO: binary/Gray write pointer,
// registered full/almost_full/level flags and a sticky overflow flag.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int FIFO_ADDR_SIZE  = 5,
    parameter int ALMOST_FULL_GAP = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [FIFO_ADDR_SIZE:0] rptr_gray_sync,
    input  logic                    ovf_clr,
    output logic                    wr_accept,
    output logic [FIFO_ADDR_SIZE-1:0] waddr,
    output logic [FIFO_ADDR_SIZE:0] wptr_gray,
    output logic                    full,
    output logic                    almost_full,
    output logic [FIFO_ADDR_SIZE:0] wr_level,
    output logic                    overflow
);

    localparam int PW    = FIFO_ADDR_SIZE + 1;
    localparam int DEPTH = fifo_depth(FIFO_ADDR_SIZE);
    localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - ALMOST_FULL_GAP);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          af_q, af_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] rbin_sync;
    ptr_word_t     wbin_wide, wgray_wide, rptr_wide;

    fifo_gray2bin #(.W(PW)) u_rptr_g2b (
        .gray_i (rptr_gray_sync),
        .bin_o  (rbin_sync)
    );

    // Write handshake: wr_en is the producer's request; a write transfers on
    // a rising edge iff wr_en=1 and the registered full=0 (wr_accept=1).
    assign wr_accept = wr_en & ~full_q;

    always_comb begin
        wbin_d     = wbin_q + {{(PW-1){1'b0}}, wr_accept};
        wbin_wide  = {{(PTR_MAX_W-PW){1'b0}}, wbin_d};
        rptr_wide  = {{(PTR_MAX_W-PW){1'b0}}, rptr_gray_sync};
        wgray_wide = bin2gray(wbin_wide);
        wgray_d    = wgray_wide[PW-1:0];
        full_d     = (wgray_wide == full_target(rptr_wide, PW));
        level_d    = wbin_d - rbin_sync;
        af_d       = (level_d >= AF_THRESH);
        // A write attempted while full sets the flag even during a clear.
        ovf_d      = (wr_en & full_q) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign waddr       = wbin_q[FIFO_ADDR_SIZE-1:0];
    assign wptr_gray   = wgray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wr_level    = level_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full: driver pushes expected state per cycle,
// a monitor pops and compares after each rising edge.
module tb_fifo_wptr_full;

    localparam logic [6:0] ALL   = 7'h7f;
    localparam logic [6:0] NOACC = 7'h7e;

    typedef struct {
        logic [6:0] m;
        logic       acc;
        logic [4:0] wa;
        logic [5:0] g;
        logic       f;
        logic       af;
        logic [5:0] lv;
        logic       ov;
        int         step;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [5:0] rptr_gray_sync;
    logic       ovf_clr;
    logic       wr_accept;
    logic [4:0] waddr;
    logic [5:0] wptr_gray;
    logic       full;
    logic       almost_full;
    logic [5:0] wr_level;
    logic       overflow;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   step_n = 0;

    fifo_wptr_full #(.FIFO_ADDR_SIZE(5), .ALMOST_FULL_GAP(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .rptr_gray_sync (rptr_gray_sync),
        .ovf_clr        (ovf_clr),
        .wr_accept      (wr_accept),
        .waddr          (waddr),
        .wptr_gray      (wptr_gray),
        .full           (full),
        .almost_full    (almost_full),
        .wr_level       (wr_level),
        .overflow       (overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [5:0] g6(input int v);
        logic [5:0] b;
        b = v[5:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input int step, input string nm, input logic en,
                       input logic [7:0] act, input logic [7:0] exp);
        if (en) begin
            n_chk++;
            if (act === exp) n_pass++;
            else $display("FAIL step %0d %s: got %0h expected %0h", step, nm, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic r, input logic we, input logic clr,
                       input logic [5:0] rp, input logic [6:0] m,
                       input logic e_acc, input logic [4:0] e_wa,
                       input logic [5:0] e_g, input logic e_f, input logic e_af,
                       input logic [5:0] e_lv, input logic e_ov);
        exp_t e;
        rst = r; wr_en = we; ovf_clr = clr; rptr_gray_sync = rp;
        e.m = m; e.acc = e_acc; e.wa = e_wa; e.g = e_g; e.f = e_f;
        e.af = e_af; e.lv = e_lv; e.ov = e_ov; e.step = step_n;
        step_n++;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        exp_t e;
        logic acc_s;
        forever begin
            @(negedge clk);
            acc_s = wr_accept;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.step, "wr_accept",   e.m[0], {7'd0, acc_s},       {7'd0, e.acc});
                chk(e.step, "waddr",       e.m[1], {3'd0, waddr},       {3'd0, e.wa});
                chk(e.step, "wptr_gray",   e.m[2], {2'd0, wptr_gray},   {2'd0, e.g});
                chk(e.step, "full",        e.m[3], {7'd0, full},        {7'd0, e.f});
                chk(e.step, "almost_full", e.m[4], {7'd0, almost_full}, {7'd0, e.af});
                chk(e.step, "wr_level",    e.m[5], {2'd0, wr_level},    {2'd0, e.lv});
                chk(e.step, "overflow",    e.m[6], {7'd0, overflow},    {7'd0, e.ov});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [5:0] prev_g;
        int rb;
        rst = 1'b1; wr_en = 1'b0; ovf_clr = 1'b0; rptr_gray_sync = 6'h00;
        @(posedge clk);
        #2;

        // Reset held two cycles with wr_en=1: nothing advances.
        cyc(1'b1, 1'b1, 1'b0, 6'h00, NOACC, 1'b0, 5'd0, 6'h00, 1'b0, 1'b0, 6'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 6'h00, NOACC, 1'b0, 5'd0, 6'h00, 1'b0, 1'b0, 6'd0, 1'b0);

        // Fill with the reader parked at 0.
        for (int i = 1; i <= 32; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 6'h00, ALL, 1'b1, 5'(i), g6(i),
                (i == 32), (i >= 28), 6'(i), 1'b0);
        end

        // Writes while full are rejected and set overflow.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 6'h00, ALL, 1'b0, 5'd0, 6'h30, 1'b1, 1'b1, 6'd32, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b1, 6'h00, ALL, 1'b0, 5'd0, 6'h30, 1'b1, 1'b1, 6'd32, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 6'h00, ALL, 1'b0, 5'd0, 6'h30, 1'b1, 1'b1, 6'd32, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 6'h00, ALL, 1'b0, 5'd0, 6'h30, 1'b1, 1'b1, 6'd32, 1'b0);

        // Reader frees one slot; the same-cycle write still sees full=1.
        cyc(1'b0, 1'b1, 1'b0, 6'h01, ALL, 1'b0, 5'd0, 6'h30, 1'b0, 1'b1, 6'd31, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 6'h01, ALL, 1'b1, 5'd1, 6'h31, 1'b1, 1'b1, 6'd32, 1'b1);

        // Reset, then the reader trails the writer by two cycles across wrap.
        cyc(1'b1, 1'b0, 1'b0, 6'h00, ALL, 1'b0, 5'd0, 6'h00, 1'b0, 1'b0, 6'd0, 1'b0);
        prev_g = 6'h00;
        for (int k = 1; k <= 100; k++) begin
            rb = (k >= 3) ? k - 3 : 0;
            cyc(1'b0, 1'b1, 1'b0, g6(rb), ALL, 1'b1, 5'(k), g6(k),
                1'b0, 1'b0, 6'(k - rb), 1'b0);
            chk(k, "gray_onebit", 1'b1, 8'($countones(wptr_gray ^ prev_g)), 8'd1);
            prev_g = wptr_gray;
        end

        // Mid-operation reset after 20 writes.
        cyc(1'b1, 1'b0, 1'b0, 6'h00, ALL, 1'b0, 5'd0, 6'h00, 1'b0, 1'b0, 6'd0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 6'h00, ALL, 1'b1, 5'(i), g6(i), 1'b0, 1'b0, 6'(i), 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b0, 6'h00, ALL, 1'b1, 5'd0, 6'h00, 1'b0, 1'b0, 6'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 6'h00, ALL, 1'b1, 5'd1, 6'h01, 1'b0, 1'b0, 6'd1, 1'b0);

        wr_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        chk(step_n, "queue_drained", 1'b1, 8'(exp_q.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
